fwd_stall_unit: RTL and testbench

FWD_STALL_UNIT -- requirements
Module: fwd_stall_unit

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/ld_scoreboard.sv | 79 +++++++
 rtl/fwd_stall_unit.sv | 130 +++++++++++++
 tb/tb_fwd_stall_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage forwarding and load-use stall logic.
// Holds forwarding select codes and the load scoreboard entry layout.
package hazard_pkg;

    // Scoreboard fields are sized for the widest supported register address
    // (RA_W up to 8) and the largest load latency (LD_LAT up to 4).
    localparam int SB_RD_W  = 8;
    localparam int SB_CNT_W = 3;

    typedef logic [2:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 3'b000;
    localparam fwd_sel_t FWD_EX  = 3'b001;
    localparam fwd_sel_t FWD_MEM = 3'b010;
    localparam fwd_sel_t FWD_LD  = 3'b011;
    localparam fwd_sel_t FWD_WB  = 3'b100;

    typedef struct packed {
        logic                valid;
        logic [SB_RD_W-1:0]  rd;
        logic [SB_CNT_W-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/ld_scoreboard.sv
// Tracks loads that have left EX until their data becomes forwardable.
// Reports, per ID source, whether a load is still in flight or retiring.
module ld_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int RA_W   = 5,
    parameter int LD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ins_valid,
    input  logic [RA_W-1:0]      ins_rd,
    input  logic [NSRC*RA_W-1:0] src_rs,
    input  logic [NSRC-1:0]      src_used,
    output logic [NSRC-1:0]      src_busy,
    output logic [NSRC-1:0]      src_retire
);

    localparam logic [SB_CNT_W-1:0] CNT_ONE  = SB_CNT_W'(1);
    localparam logic [SB_CNT_W-1:0] CNT_INIT = SB_CNT_W'(LD_LAT);

    sb_entry_t [LD_LAT-1:0] sb_q;
    sb_entry_t [LD_LAT-1:0] sb_d;
    logic                   ins_done;

    // Age every entry, free the retiring one, then place a new load in the
    // first slot that is empty after aging (one always exists).
    always_comb begin
        sb_d     = sb_q;
        ins_done = 1'b0;
        for (int i = 0; i < LD_LAT; i++) begin
            if (sb_q[i].valid) begin
                if (sb_q[i].cnt == CNT_ONE) begin
                    sb_d[i] = '0;
                end else begin
                    sb_d[i].cnt = sb_q[i].cnt - CNT_ONE;
                end
            end
        end
        for (int i = 0; i < LD_LAT; i++) begin
            if (ins_valid && !ins_done && !sb_d[i].valid) begin
                sb_d[i].valid = 1'b1;
                sb_d[i].rd    = SB_RD_W'(ins_rd);
                sb_d[i].cnt   = CNT_INIT;
                ins_done      = 1'b1;
            end
        end
    end

    // Retire only when no younger (still counting) load to the same rd exists.
    always_comb begin
        src_busy   = '0;
        src_retire = '0;
        for (int k = 0; k < NSRC; k++) begin
            for (int i = 0; i < LD_LAT; i++) begin
                if (src_used[k] && sb_q[i].valid &&
                    sb_q[i].rd == SB_RD_W'(src_rs[k*RA_W +: RA_W])) begin
                    if (sb_q[i].cnt == CNT_ONE) begin
                        src_retire[k] = 1'b1;
                    end else begin
                        src_busy[k] = 1'b1;
                    end
                end
            end
            src_retire[k] = src_retire[k] & ~src_busy[k];
        end
    end

    // Scoreboard state register; reset wins over a same-cycle insertion.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: rtl/fwd_stall_unit.sv
// ID-stage operand forwarding select and load-use stall generation.
// Also keeps saturating stall-cycle and flush counters.
module fwd_stall_unit
    import hazard_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int RA_W   = 5,
    parameter int LD_LAT = 2,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NSRC*RA_W-1:0] id_rs,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic                 ex_valid,
    input  logic                 ex_wen,
    input  logic                 ex_is_load,
    input  logic [RA_W-1:0]      ex_rd,
    input  logic                 mem_valid,
    input  logic                 mem_wen,
    input  logic [RA_W-1:0]      mem_rd,
    input  logic                 wb_valid,
    input  logic                 wb_wen,
    input  logic [RA_W-1:0]      wb_rd,
    input  logic                 flush,
    output logic [NSRC*3-1:0]    fwd_sel,
    output logic                 stall_id,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NSRC-1:0]  id_use;
    logic [NSRC-1:0]  ex_hit;
    logic [NSRC-1:0]  mem_hit;
    logic [NSRC-1:0]  wb_hit;
    logic [NSRC-1:0]  sb_busy;
    logic [NSRC-1:0]  sb_retire;
    logic [NSRC-1:0]  stall_src;
    logic             ins_valid;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q;
    logic [CNT_W-1:0] flush_count_d;

    assign id_use    = {NSRC{id_valid}} & id_rs_used;
    assign ins_valid = ex_valid & ex_wen & ex_is_load & (|ex_rd) & ~flush;

    ld_scoreboard #(
        .NSRC   (NSRC),
        .RA_W   (RA_W),
        .LD_LAT (LD_LAT)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_rd     (ex_rd),
        .src_rs     (id_rs),
        .src_used   (id_use),
        .src_busy   (sb_busy),
        .src_retire (sb_retire)
    );

    // Stage hits per source; x0 is never a producer.
    always_comb begin
        ex_hit  = '0;
        mem_hit = '0;
        wb_hit  = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (id_use[k] && (|id_rs[k*RA_W +: RA_W])) begin
                ex_hit[k]  = ex_valid && ex_wen &&
                             ex_rd == id_rs[k*RA_W +: RA_W];
                mem_hit[k] = mem_valid && mem_wen &&
                             mem_rd == id_rs[k*RA_W +: RA_W];
                wb_hit[k]  = wb_valid && wb_wen &&
                             wb_rd == id_rs[k*RA_W +: RA_W];
            end
        end
    end

    // Youngest producer wins the select; loads not yet forwardable stall.
    always_comb begin
        fwd_sel   = '0;
        stall_src = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (ex_hit[k] && !ex_is_load) begin
                fwd_sel[k*3 +: 3] = FWD_EX;
            end else if (sb_retire[k]) begin
                fwd_sel[k*3 +: 3] = FWD_LD;
            end else if (mem_hit[k]) begin
                fwd_sel[k*3 +: 3] = FWD_MEM;
            end else if (wb_hit[k]) begin
                fwd_sel[k*3 +: 3] = FWD_WB;
            end else begin
                fwd_sel[k*3 +: 3] = FWD_RF;
            end
            stall_src[k] = (ex_hit[k] && ex_is_load) || sb_busy[k];
        end
        stall_id = (|stall_src) & ~flush;
    end

    // Saturating next-count for both performance counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall_id && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end
        if (flush && !(&flush_count_q)) begin
            flush_count_d = flush_count_q + CNT_ONE;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Self-checking bench for fwd_stall_unit: directed table, hand sequences
// and random traffic against a queue-based model of in-flight loads.
module tb_fwd_stall_unit;

    localparam int NSRC  = 2;
    localparam int RA_W  = 5;
    localparam int LDL   = 2;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 id_valid;
    logic [NSRC*RA_W-1:0] id_rs;
    logic [NSRC-1:0]      id_rs_used;
    logic                 ex_valid, ex_wen, ex_is_load;
    logic [RA_W-1:0]      ex_rd;
    logic                 mem_valid, mem_wen;
    logic [RA_W-1:0]      mem_rd;
    logic                 wb_valid, wb_wen;
    logic [RA_W-1:0]      wb_rd;
    logic                 flush;
    logic [NSRC*3-1:0]    fwd_sel;
    logic                 stall_id;
    logic [CNT_W-1:0]     stall_cycles;
    logic [CNT_W-1:0]     flush_count;

    fwd_stall_unit #(
        .NSRC(NSRC), .RA_W(RA_W), .LD_LAT(LDL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
        .flush(flush),
        .fwd_sel(fwd_sel), .stall_id(stall_id),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: loads that left EX, oldest first, with cycles since leaving.
    typedef struct {
        logic [RA_W-1:0] rd;
        int              age;
    } ld_t;
    ld_t ldq[$];
    int  m_sc;
    int  m_fc;

    typedef struct packed {
        logic       idv;
        logic [4:0] rs2, rs1;
        logic [1:0] used;
        logic       exv, exw, exl;
        logic [4:0] exrd;
        logic       mv, mw;
        logic [4:0] mrd;
        logic       wv, ww;
        logic [4:0] wrd;
        logic       fl;
        logic [5:0] esel;
        logic       est;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void model_eval(output logic [5:0] sel,
                                       output logic st);
        sel = '0;
        st  = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            logic [4:0] rs;
            logic       u, exh, memh, wbh, ldb, ldr;
            int         code;
            rs   = id_rs[k*RA_W +: RA_W];
            u    = id_valid && id_rs_used[k] && rs != 0;
            exh  = u && ex_valid && ex_wen && ex_rd == rs;
            memh = u && mem_valid && mem_wen && mem_rd == rs;
            wbh  = u && wb_valid && wb_wen && wb_rd == rs;
            ldb  = 1'b0;
            ldr  = 1'b0;
            for (int j = ldq.size() - 1; j >= 0; j--) begin
                if (u && ldq[j].rd == rs) begin
                    ldb = ldq[j].age < LDL - 1;
                    ldr = ldq[j].age == LDL - 1;
                    break;
                end
            end
            if (exh && !ex_is_load) code = 1;
            else if (ldr)           code = 3;
            else if (memh)          code = 2;
            else if (wbh)           code = 4;
            else                    code = 0;
            sel[k*3 +: 3] = 3'(code);
            if ((exh && ex_is_load) || ldb) st = 1'b1;
        end
        if (flush) st = 1'b0;
    endfunction

    task automatic model_update(input logic st);
        if (rst) begin
            ldq.delete();
            m_sc = 0;
            m_fc = 0;
        end else begin
            if (st && m_sc < CMAX) m_sc++;
            if (flush && m_fc < CMAX) m_fc++;
            for (int j = ldq.size() - 1; j >= 0; j--) begin
                ldq[j].age++;
                if (ldq[j].age >= LDL) ldq.delete(j);
            end
            if (ex_valid && ex_wen && ex_is_load && ex_rd != 0 && !flush)
                ldq.push_back('{rd: ex_rd, age: 0});
        end
    endtask

    // One clock: compare at negedge against model and optional hand values.
    task automatic tick(input string tag, input int hsel, input int hst,
                        input int hsc, input int hfc);
        logic [5:0] es;
        logic       est;
        @(negedge clk);
        model_eval(es, est);
        check({tag, " sel"}, int'(fwd_sel), int'(es));
        check({tag, " stall"}, int'(stall_id), int'(est));
        check({tag, " stall_cycles"}, int'(stall_cycles), m_sc);
        check({tag, " flush_count"}, int'(flush_count), m_fc);
        if (hsel >= 0) check({tag, " hand sel"}, int'(fwd_sel), hsel);
        if (hst >= 0) check({tag, " hand stall"}, int'(stall_id), hst);
        if (hsc >= 0) check({tag, " hand stall_cycles"},
                            int'(stall_cycles), hsc);
        if (hfc >= 0) check({tag, " hand flush_count"},
                            int'(flush_count), hfc);
        @(posedge clk);
        model_update(est);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = '0; id_rs_used = '0;
        ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_rd = '0;
        mem_valid = 0; mem_wen = 0; mem_rd = '0;
        wb_valid = 0; wb_wen = 0; wb_rd = '0;
        flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick("reset", 0, 0, -1, -1);
        rst = 0;
    endtask

    task automatic set_ex(input logic v, input logic w, input logic l,
                          input logic [4:0] rd);
        ex_valid = v; ex_wen = w; ex_is_load = l; ex_rd = rd;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r2,
                          input logic [4:0] r1, input logic [1:0] u);
        id_valid = v; id_rs = {r2, r1}; id_rs_used = u;
    endtask

    function automatic vec_t mk(
        input logic idv, input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [1:0] used, input logic exv, input logic exw,
        input logic exl, input logic [4:0] exrd, input logic mv,
        input logic mw, input logic [4:0] mrd, input logic wv,
        input logic ww, input logic [4:0] wrd, input logic fl,
        input logic [5:0] esel, input logic est);
        vec_t v;
        v = {idv, rs2, rs1, used, exv, exw, exl, exrd,
             mv, mw, mrd, wv, ww, wrd, fl, esel, est};
        return v;
    endfunction

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        ldq.delete();
        m_sc = 0;
        m_fc = 0;
        rst = 0;
        tick("post reset", 0, 0, 0, 0);

        vecs[0]  = mk(1, 0, 5, 2'b01, 1,1,0,5, 0,0,0, 0,0,0, 0, 6'o01, 0);
        vecs[1]  = mk(1, 0, 0, 2'b01, 1,1,1,0, 0,0,0, 0,0,0, 0, 6'o00, 0);
        vecs[2]  = mk(1, 0, 4, 2'b01, 1,1,0,4, 0,0,0, 1,1,4, 0, 6'o01, 0);
        vecs[3]  = mk(1, 0, 4, 2'b00, 1,1,0,4, 0,0,0, 1,1,4, 0, 6'o00, 0);
        vecs[4]  = mk(1, 8, 0, 2'b10, 0,0,0,0, 1,1,8, 0,0,0, 0, 6'o20, 0);
        vecs[5]  = mk(1, 9, 3, 2'b11, 0,0,0,0, 1,1,9, 1,1,3, 0, 6'o24, 0);
        vecs[6]  = mk(1, 0, 2, 2'b01, 0,0,0,0, 1,1,2, 1,1,2, 0, 6'o02, 0);
        vecs[7]  = mk(1, 7, 0, 2'b10, 1,1,1,7, 0,0,0, 0,0,0, 0, 6'o00, 1);
        vecs[8]  = mk(1, 7, 0, 2'b10, 1,1,1,7, 0,0,0, 0,0,0, 1, 6'o00, 0);
        vecs[9]  = mk(0, 0, 5, 2'b01, 1,1,0,5, 0,0,0, 0,0,0, 0, 6'o00, 0);
        vecs[10] = mk(1, 0, 6, 2'b01, 1,0,0,6, 1,1,6, 0,0,0, 0, 6'o02, 0);
        vecs[11] = mk(1, 1, 1, 2'b11, 1,1,0,1, 0,0,0, 1,1,1, 0, 6'o11, 0);

        for (int i = 0; i < 12; i++) begin
            do_reset();
            set_id(vecs[i].idv, vecs[i].rs2, vecs[i].rs1, vecs[i].used);
            set_ex(vecs[i].exv, vecs[i].exw, vecs[i].exl, vecs[i].exrd);
            mem_valid = vecs[i].mv; mem_wen = vecs[i].mw;
            mem_rd = vecs[i].mrd;
            wb_valid = vecs[i].wv; wb_wen = vecs[i].ww; wb_rd = vecs[i].wrd;
            flush = vecs[i].fl;
            tick($sformatf("vec%0d", i), int'(vecs[i].esel),
                 int'(vecs[i].est), -1, -1);
        end

        // Load-use on rs2: two stall cycles then load forward.
        do_reset();
        set_id(1, 7, 0, 2'b10);
        set_ex(1, 1, 1, 7);
        tick("lduse c0", 0, 1, 0, -1);
        set_ex(0, 0, 0, 0);
        tick("lduse c1", 0, 1, 1, -1);
        tick("lduse c2", 6'o30, 0, 2, -1);

        // Flushed load is dropped; older x3 retires on schedule.
        do_reset();
        set_ex(1, 1, 1, 3);
        tick("flush c0", 0, 0, -1, 0);
        set_ex(1, 1, 1, 9);
        set_id(1, 9, 3, 2'b11);
        flush = 1;
        tick("flush c1", 0, 0, -1, 0);
        flush = 0;
        set_ex(0, 0, 0, 0);
        tick("flush c2", 6'o03, 0, 0, 1);

        // Back-to-back loads to x6: wait for the younger one.
        do_reset();
        set_ex(1, 1, 1, 6);
        tick("b2b c0", 0, 0, -1, -1);
        set_id(1, 0, 6, 2'b01);
        tick("b2b c1", 0, 1, -1, -1);
        set_ex(0, 0, 0, 0);
        tick("b2b c2", 0, 1, -1, -1);
        tick("b2b c3", 6'o03, 0, -1, -1);

        // Reset asserted in the middle of a load-use stall.
        do_reset();
        set_id(1, 0, 7, 2'b01);
        set_ex(1, 1, 1, 7);
        tick("rstmid c0", 0, 1, -1, -1);
        set_ex(0, 0, 0, 0);
        rst = 1;
        tick("rstmid c1", 0, 1, -1, -1);
        rst = 0;
        tick("rstmid c2", 0, 0, 0, 0);

        // Random traffic on a small register set for frequent hazards.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            id_valid   = ($urandom_range(3) != 0);
            id_rs      = {5'($urandom_range(7)), 5'($urandom_range(7))};
            id_rs_used = 2'($urandom_range(3));
            ex_valid   = $urandom_range(1);
            ex_wen     = ($urandom_range(3) != 0);
            ex_is_load = $urandom_range(1);
            ex_rd      = 5'($urandom_range(7));
            mem_valid  = $urandom_range(1);
            mem_wen    = $urandom_range(1);
            mem_rd     = 5'($urandom_range(7));
            wb_valid   = $urandom_range(1);
            wb_wen     = $urandom_range(1);
            wb_rd      = 5'($urandom_range(7));
            flush      = ($urandom_range(15) == 0);
            rst        = ($urandom_range(199) == 0);
            tick("rand", -1, -1, -1, -1);
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
